// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: prefetch entry layout,
// the ARM no-op word and the PC increment per fetched word.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; wrapping pointers and a separate
// occupancy count so a full FIFO can push and pop in one cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot being written
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues word requests and buffers
// in-order responses for the decoder; redirects flush and drop.
module instr_fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
    input  logic        consume,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    import fetch_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] CREDITS = DEPTH[CW:0];

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   last_pc;
    logic [31:0]   target;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic          empty;
    logic          issue;
    logic          push;
    logic          pop;
    logic          unused_pc_bits;
    fetch_entry_t  head;
    fetch_entry_t  wentry;

    assign target         = {redirect_pc[31:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];

    // stale in-flight requests still hold a credit until they return
    assign imem_req  = !reset && !redirect &&
                       (({1'b0, count} + {1'b0, outstanding}) < CREDITS);
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_ready;

    assign push = imem_rvalid && (drop == '0) && !redirect;
    assign pop  = consume && !empty && !redirect;

    assign wentry.instr = imem_rdata;
    assign wentry.pc    = rsp_pc;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .count (count),
        .empty (empty)
    );

    assign instr_valid = !empty;
    assign Instr       = empty ? NOP_INSTR : head.instr;
    assign instr_pc    = empty ? last_pc : head.pc;

    always_comb begin
        outstanding_nxt = outstanding;
        unique case (1'b1)
            issue && !imem_rvalid: outstanding_nxt = outstanding + 1'b1;
            imem_rvalid && !issue: outstanding_nxt = outstanding - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            last_pc     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (!empty) begin
                last_pc <= head.pc;
            end
            if (redirect) begin
                fetch_pc <= target;
                rsp_pc   <= target;
                // everything still in flight after this cycle is stale
                drop     <= outstanding_nxt;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + PC_STEP;
                end
                if (imem_rvalid && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && imem_rvalid) begin
            assert (outstanding != '0);
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: two instances (RESET_PC 0 and near wrap)
// against a queue-based memory and consumer reference model.
module tb_instr_fetch_queue;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ready;
    logic        consume;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        req    [2];
    logic [31:0] addr   [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];
    logic [31:0] instr  [2];
    logic        ivalid [2];
    logic [31:0] ipc    [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int lat    = 1;
    int pops   = 0;
    bit chk_en = 1'b0;

    logic [31:0] exp_fetch [2];
    logic [31:0] exp_head  [2];
    logic [31:0] last_pc   [2];
    int          buffered  [2];
    int          m_head    [2];
    int          m_cnt     [2];
    logic [31:0] m_addr    [2][16];
    int          m_due     [2][16];
    bit          m_stale   [2][16];

    logic        s_req   [2];
    logic        s_fire  [2];
    logic        s_rv    [2];
    logic        s_valid [2];
    logic [31:0] s_addr  [2];
    logic [31:0] s_pc    [2];
    logic [31:0] s_instr [2];

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .DEPTH(4), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(req[0]), .imem_addr(addr[0]), .imem_ready(imem_ready),
        .imem_rvalid(rvalid[0]), .imem_rdata(rdata[0]),
        .Instr(instr[0]), .instr_valid(ivalid[0]), .instr_pc(ipc[0]),
        .consume(consume), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    instr_fetch_queue #(
        .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP)
    ) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(req[1]), .imem_addr(addr[1]), .imem_ready(imem_ready),
        .imem_rvalid(rvalid[1]), .imem_rdata(rdata[1]),
        .Instr(instr[1]), .instr_valid(ivalid[1]), .instr_pc(ipc[1]),
        .consume(consume), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    function automatic logic [31:0] rpc(input int i);
        return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_fetch[i] = rpc(i);
            exp_head[i]  = rpc(i);
            last_pc[i]   = '0;
            buffered[i]  = 0;
            m_head[i]    = 0;
            m_cnt[i]     = 0;
            rvalid[i]    = 1'b0;
            rdata[i]     = '0;
        end
    endtask

    // memory answers oldest request once its latency has elapsed
    task automatic drive_mem();
        for (int i = 0; i < 2; i++) begin
            if (m_cnt[i] > 0 && m_due[i][m_head[i]] <= cyc) begin
                rvalid[i] = 1'b1;
                rdata[i]  = word(m_addr[i][m_head[i]]);
            end else begin
                rvalid[i] = 1'b0;
                rdata[i]  = $urandom;
            end
        end
    endtask

    task automatic cycle();
        logic exp_req;
        int   idx;
        #1;
        for (int i = 0; i < 2; i++) begin
            s_req[i]   = req[i];
            s_addr[i]  = addr[i];
            s_valid[i] = ivalid[i];
            s_pc[i]    = ipc[i];
            s_instr[i] = instr[i];
            s_rv[i]    = rvalid[i];
            s_fire[i]  = (req[i] === 1'b1) && imem_ready;
            if (chk_en) begin
                exp_req = !reset && !redirect && (buffered[i] + m_cnt[i] < 4);
                checks++;
                if (req[i] !== exp_req) begin
                    errors++;
                    $display("FAIL imem_req[%0d] cyc %0d: got %b want %b",
                             i, cyc, req[i], exp_req);
                end
                checks++;
                if (ivalid[i] !== (buffered[i] > 0)) begin
                    errors++;
                    $display("FAIL instr_valid[%0d] cyc %0d: got %b want %b",
                             i, cyc, ivalid[i], buffered[i] > 0);
                end
                if (buffered[i] > 0) begin
                    checks++;
                    if (ipc[i] !== exp_head[i]) begin
                        errors++;
                        $display("FAIL instr_pc[%0d] cyc %0d: got %h want %h",
                                 i, cyc, ipc[i], exp_head[i]);
                    end
                    checks++;
                    if (instr[i] !== word(exp_head[i])) begin
                        errors++;
                        $display("FAIL Instr[%0d] cyc %0d: got %h want %h",
                                 i, cyc, instr[i], word(exp_head[i]));
                    end
                end else begin
                    checks++;
                    if (instr[i] !== NOP) begin
                        errors++;
                        $display("FAIL Instr_nop[%0d] cyc %0d: got %h want %h",
                                 i, cyc, instr[i], NOP);
                    end
                    checks++;
                    if (ipc[i] !== last_pc[i]) begin
                        errors++;
                        $display("FAIL instr_pc_hold[%0d] cyc %0d: got %h want %h",
                                 i, cyc, ipc[i], last_pc[i]);
                    end
                end
                if (s_fire[i]) begin
                    checks++;
                    if (addr[i] !== exp_fetch[i]) begin
                        errors++;
                        $display("FAIL imem_addr[%0d] cyc %0d: got %h want %h",
                                 i, cyc, addr[i], exp_fetch[i]);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                exp_fetch[i] = rpc(i);
                exp_head[i]  = rpc(i);
                last_pc[i]   = '0;
                buffered[i]  = 0;
                m_head[i]    = 0;
                m_cnt[i]     = 0;
            end else begin
                if (buffered[i] > 0) last_pc[i] = exp_head[i];
                if (consume && buffered[i] > 0 && !redirect) begin
                    buffered[i]--;
                    exp_head[i] = exp_head[i] + 32'd4;
                    if (i == 0) pops++;
                end
                if (s_rv[i]) begin
                    if (!m_stale[i][m_head[i]] && !redirect) buffered[i]++;
                    m_head[i] = (m_head[i] + 1) % 16;
                    m_cnt[i]--;
                end
                if (s_fire[i]) begin
                    if (m_cnt[i] < 16) begin
                        idx = (m_head[i] + m_cnt[i]) % 16;
                        m_addr[i][idx]  = s_addr[i];
                        m_due[i][idx]   = cyc + lat;
                        m_stale[i][idx] = 1'b0;
                        m_cnt[i]++;
                    end else begin
                        errors++;
                        $display("FAIL inflight_bound[%0d] cyc %0d: got %0d want <16",
                                 i, cyc, m_cnt[i]);
                    end
                    exp_fetch[i] = exp_fetch[i] + 32'd4;
                end
                if (redirect) begin
                    buffered[i] = 0;
                    for (int k = 0; k < 16; k++) m_stale[i][k] = 1'b1;
                    exp_fetch[i] = {redirect_pc[31:2], 2'b00};
                    exp_head[i]  = {redirect_pc[31:2], 2'b00};
                end
            end
        end
        cyc++;
        drive_mem();
    endtask

    task automatic do_reset(input int n);
        reset      = 1'b1;
        redirect   = 1'b0;
        consume    = 1'b0;
        imem_ready = 1'b0;
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (s_req[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_req[%0d]: got %b want 0", i, s_req[i]);
            end
            checks++;
            if (s_valid[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid[%0d]: got %b want 0", i, s_valid[i]);
            end
            checks++;
            if (s_instr[i] !== NOP) begin
                errors++;
                $display("FAIL reset_instr[%0d]: got %h want %h", i, s_instr[i], NOP);
            end
            checks++;
            if (s_pc[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_pc[%0d]: got %h want 0", i, s_pc[i]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] a [2][3];
        logic [31:0] p [2][3];
        int nv [2];
        int first_valid;
        logic [31:0] e;
        do_reset(1);
        lat = 1;
        imem_ready = 1'b1;
        consume = 1'b1;
        first_valid = -1;
        nv[0] = 0;
        nv[1] = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                if (k < 3) a[i][k] = s_fire[i] ? s_addr[i] : 32'hDEAD_BEEF;
                if (s_valid[i] === 1'b1 && nv[i] < 3) begin
                    p[i][nv[i]] = s_pc[i];
                    nv[i]++;
                end
            end
            if (first_valid < 0 && s_valid[0] === 1'b1) first_valid = k;
        end
        checks++;
        if (first_valid != 2) begin
            errors++;
            $display("FAIL stream_latency: got %0d want 2", first_valid);
        end
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) begin
                e = rpc(i) + 32'(4 * k);
                checks++;
                if (a[i][k] !== e) begin
                    errors++;
                    $display("FAIL stream_addr[%0d][%0d]: got %h want %h", i, k, a[i][k], e);
                end
                checks++;
                if (nv[i] != 3 || p[i][k] !== e) begin
                    errors++;
                    $display("FAIL stream_pc[%0d][%0d]: got %h want %h", i, k, p[i][k], e);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n [2];
        do_reset(1);
        lat = 1;
        imem_ready = 1'b1;
        consume = 1'b0;
        n[0] = 0;
        n[1] = 0;
        repeat (10) begin
            cycle();
            for (int i = 0; i < 2; i++) if (s_fire[i]) n[i]++;
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (n[i] != 4) begin
                errors++;
                $display("FAIL bp_requests[%0d]: got %0d want 4", i, n[i]);
            end
            checks++;
            if (s_req[i] !== 1'b0 || s_valid[i] !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got req=%b valid=%b want req=0 valid=1",
                         i, s_req[i], s_valid[i]);
            end
            checks++;
            if (s_instr[i] !== word(rpc(i))) begin
                errors++;
                $display("FAIL bp_instr[%0d]: got %h want %h", i, s_instr[i], word(rpc(i)));
            end
        end
        consume = 1'b1;
        cycle();
        consume = 1'b0;
        n[0] = 0;
        n[1] = 0;
        repeat (6) begin
            cycle();
            for (int i = 0; i < 2; i++) if (s_fire[i]) n[i]++;
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (n[i] != 1) begin
                errors++;
                $display("FAIL bp_refill[%0d]: got %0d want 1", i, n[i]);
            end
        end
    endtask

    task automatic test_redirect_inflight();
        logic [31:0] fp [2];
        logic [31:0] fi [2];
        bit seen [2];
        do_reset(1);
        lat = 3;
        imem_ready = 1'b1;
        consume = 1'b1;
        cycle();
        cycle();
        imem_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        cycle();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (s_req[i] !== 1'b0) begin
                errors++;
                $display("FAIL redir_req[%0d]: got %b want 0", i, s_req[i]);
            end
            seen[i] = 1'b0;
            fp[i] = '0;
            fi[i] = '0;
        end
        redirect = 1'b0;
        imem_ready = 1'b1;
        repeat (12) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                if (!seen[i] && s_valid[i] === 1'b1) begin
                    seen[i] = 1'b1;
                    fp[i] = s_pc[i];
                    fi[i] = s_instr[i];
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (!seen[i] || fp[i] !== 32'h100 || fi[i] !== word(32'h100)) begin
                errors++;
                $display("FAIL redir_first[%0d]: got pc=%h instr=%h want pc=100 instr=%h",
                         i, fp[i], fi[i], word(32'h100));
            end
        end
    endtask

    task automatic test_redirect_consume_full();
        do_reset(1);
        lat = 1;
        imem_ready = 1'b1;
        consume = 1'b0;
        repeat (8) cycle();
        redirect = 1'b1;
        consume = 1'b1;
        redirect_pc = 32'h0000_0200;
        cycle();
        redirect = 1'b0;
        consume = 1'b0;
        cycle();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (s_valid[i] !== 1'b0 || s_instr[i] !== NOP) begin
                errors++;
                $display("FAIL flush[%0d]: got valid=%b instr=%h want valid=0 instr=%h",
                         i, s_valid[i], s_instr[i], NOP);
            end
            checks++;
            if (s_pc[i] !== rpc(i)) begin
                errors++;
                $display("FAIL flush_pc[%0d]: got %h want %h", i, s_pc[i], rpc(i));
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset(1);
        lat = 3;
        imem_ready = 1'b1;
        consume = 1'b0;
        repeat (5) cycle();
        cycle();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (s_valid[i] !== 1'b1 || s_req[i] !== 1'b0) begin
                errors++;
                $display("FAIL mid_pre[%0d]: got valid=%b req=%b want valid=1 req=0",
                         i, s_valid[i], s_req[i]);
            end
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (s_valid[i] !== 1'b0 || s_instr[i] !== NOP || s_pc[i] !== 32'h0) begin
                errors++;
                $display("FAIL mid_reset[%0d]: got valid=%b instr=%h pc=%h want 0/%h/0",
                         i, s_valid[i], s_instr[i], s_pc[i], NOP);
            end
            checks++;
            if (s_req[i] !== 1'b1 || s_addr[i] !== rpc(i)) begin
                errors++;
                $display("FAIL mid_restart[%0d]: got req=%b addr=%h want 1/%h",
                         i, s_req[i], s_addr[i], rpc(i));
            end
        end
        consume = 1'b1;
        repeat (8) cycle();
    endtask

    task automatic test_random();
        int start;
        do_reset(1);
        start = pops;
        for (int k = 0; k < 3000; k++) begin
            if (k % 250 == 0) lat = $urandom_range(1, 4);
            imem_ready = ($urandom_range(0, 3) != 0);
            consume    = ($urandom_range(0, 2) != 0);
            redirect   = ($urandom_range(0, 24) == 0);
            reset      = ($urandom_range(0, 599) == 0);
            case ($urandom_range(0, 2))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                default: redirect_pc = $urandom & 32'hFFF;
            endcase
            cycle();
        end
        reset = 1'b0;
        redirect = 1'b0;
        checks++;
        if (pops - start < 300) begin
            errors++;
            $display("FAIL random_progress: got %0d pops want >=300", pops - start);
        end
    endtask

    initial begin
        reset       = 1'b1;
        imem_ready  = 1'b0;
        consume     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_consume_full();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
